// File: rtl/seg_id_ex_pipe.sv
// Decode-to-execute pipeline register with valid/ready style flow control.
// Define SEG_ID_EX_SKID_EN for a main+skid register pair; default build is a single register.
module seg_id_ex_pipe #(
  parameter int LANES  = 6,
  parameter int LANE_W = 8,
  parameter int IMM_W  = 8,
  parameter int CTRL_W = 8,
  parameter int WA_W   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ValidD,
  output logic                      StallD,
  input  logic [CTRL_W-1:0]         CtrlD,
  input  logic [WA_W-1:0]           WA3D,
  input  logic [LANES*LANE_W-1:0]   rd1D,
  input  logic [LANES*LANE_W-1:0]   rd2D,
  input  logic [IMM_W-1:0]          ExtImmD,
  input  logic                      FlushE,
  input  logic                      StallE,
  output logic                      ValidE,
  output logic [CTRL_W-1:0]         CtrlE,
  output logic [WA_W-1:0]           WA3E,
  output logic [LANES*LANE_W-1:0]   rd1E,
  output logic [LANES*LANE_W-1:0]   rd2E,
  output logic [IMM_W-1:0]          ExtImmE,
  output logic [1:0]                OccE
);

  localparam int DW = LANES * LANE_W;

  // Handshake: an entry moves on a posedge only when its valid and the
  // receiver's ready (~StallD upstream, ~StallE downstream) are both high;
  // FlushE blocks both transfers and reset overrides everything.
  logic              m_valid;
  logic [CTRL_W-1:0] m_ctrl;
  logic [WA_W-1:0]   m_wa;
  logic [DW-1:0]     m_rd1;
  logic [DW-1:0]     m_rd2;
  logic [IMM_W-1:0]  m_imm;

  logic accept;
  logic consume;

  assign accept  = ValidD & ~StallD & ~FlushE;
  assign consume = m_valid & ~StallE & ~FlushE;

  assign ValidE  = m_valid;
  assign CtrlE   = m_ctrl;
  assign WA3E    = m_wa;
  assign rd1E    = m_rd1;
  assign rd2E    = m_rd2;
  assign ExtImmE = m_imm;

`ifdef SEG_ID_EX_SKID_EN

  logic              s_valid;
  logic [CTRL_W-1:0] s_ctrl;
  logic [WA_W-1:0]   s_wa;
  logic [DW-1:0]     s_rd1;
  logic [DW-1:0]     s_rd2;
  logic [IMM_W-1:0]  s_imm;

  // Skid is only ever occupied behind a valid main entry, so a valid skid
  // means the stage is full and is itself the registered back-pressure.
  assign StallD = s_valid;
  assign OccE   = {s_valid, m_valid & ~s_valid};

  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      m_valid <= 1'b0;
      m_ctrl  <= '0;
      m_wa    <= '0;
      m_rd1   <= '0;
      m_rd2   <= '0;
      m_imm   <= '0;
      s_valid <= 1'b0;
      s_ctrl  <= '0;
      s_wa    <= '0;
      s_rd1   <= '0;
      s_rd2   <= '0;
      s_imm   <= '0;
    end else if (consume) begin
      if (s_valid) begin
        m_ctrl  <= s_ctrl;
        m_wa    <= s_wa;
        m_rd1   <= s_rd1;
        m_rd2   <= s_rd2;
        m_imm   <= s_imm;
        s_valid <= 1'b0;
        s_ctrl  <= '0;
        s_wa    <= '0;
      end else if (accept) begin
        m_ctrl  <= CtrlD;
        m_wa    <= WA3D;
        m_rd1   <= rd1D;
        m_rd2   <= rd2D;
        m_imm   <= ExtImmD;
      end else begin
        m_valid <= 1'b0;
        m_ctrl  <= '0;
        m_wa    <= '0;
      end
    end else if (accept) begin
      if (m_valid) begin
        s_valid <= 1'b1;
        s_ctrl  <= CtrlD;
        s_wa    <= WA3D;
        s_rd1   <= rd1D;
        s_rd2   <= rd2D;
        s_imm   <= ExtImmD;
      end else begin
        m_valid <= 1'b1;
        m_ctrl  <= CtrlD;
        m_wa    <= WA3D;
        m_rd1   <= rd1D;
        m_rd2   <= rd2D;
        m_imm   <= ExtImmD;
      end
    end
  end

`else

  // Single entry: decode may load only when the register is empty or
  // draining this cycle, so back-pressure is combinational.
  assign StallD = m_valid & StallE & ~FlushE;
  assign OccE   = {1'b0, m_valid};

  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      m_valid <= 1'b0;
      m_ctrl  <= '0;
      m_wa    <= '0;
      m_rd1   <= '0;
      m_rd2   <= '0;
      m_imm   <= '0;
    end else if (accept) begin
      m_valid <= 1'b1;
      m_ctrl  <= CtrlD;
      m_wa    <= WA3D;
      m_rd1   <= rd1D;
      m_rd2   <= rd2D;
      m_imm   <= ExtImmD;
    end else if (consume) begin
      // Bubble: control zeroed so a stale op cannot write, data kept.
      m_valid <= 1'b0;
      m_ctrl  <= '0;
      m_wa    <= '0;
    end
  end

`endif

endmodule

// File: tb/tb_seg_id_ex_pipe.sv
// Directed + scoreboard bench for seg_id_ex_pipe; covers both buffering modes
// selected by SEG_ID_EX_SKID_EN.
module tb_seg_id_ex_pipe;

  localparam int LANES  = 6;
  localparam int LANE_W = 8;
  localparam int IMM_W  = 8;
  localparam int CTRL_W = 8;
  localparam int WA_W   = 4;
  localparam int DW     = LANES * LANE_W;
  localparam int W      = CTRL_W + WA_W + LANE_W;

  logic              clk;
  logic              reset;
  logic              ValidD;
  logic              StallD;
  logic [CTRL_W-1:0] CtrlD;
  logic [WA_W-1:0]   WA3D;
  logic [DW-1:0]     rd1D;
  logic [DW-1:0]     rd2D;
  logic [IMM_W-1:0]  ExtImmD;
  logic              FlushE;
  logic              StallE;
  logic              ValidE;
  logic [CTRL_W-1:0] CtrlE;
  logic [WA_W-1:0]   WA3E;
  logic [DW-1:0]     rd1E;
  logic [DW-1:0]     rd2E;
  logic [IMM_W-1:0]  ExtImmE;
  logic [1:0]        OccE;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [W-1:0] exp_q[$];

  seg_id_ex_pipe #(
    .LANES(LANES), .LANE_W(LANE_W), .IMM_W(IMM_W), .CTRL_W(CTRL_W), .WA_W(WA_W)
  ) dut (
    .clk(clk), .reset(reset), .ValidD(ValidD), .StallD(StallD),
    .CtrlD(CtrlD), .WA3D(WA3D), .rd1D(rd1D), .rd2D(rd2D), .ExtImmD(ExtImmD),
    .FlushE(FlushE), .StallE(StallE), .ValidE(ValidE), .CtrlE(CtrlE),
    .WA3E(WA3E), .rd1E(rd1E), .rd2E(rd2E), .ExtImmE(ExtImmE), .OccE(OccE)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ValidD  = 1'b0;
    CtrlD   = '0;
    WA3D    = '0;
    rd1D    = '0;
    rd2D    = '0;
    ExtImmD = '0;
  endtask

  task automatic send(input logic [CTRL_W-1:0] c, input logic [WA_W-1:0] wa,
                      input logic [DW-1:0] r1, input logic [DW-1:0] r2,
                      input logic [IMM_W-1:0] imm);
    ValidD  = 1'b1;
    CtrlD   = c;
    WA3D    = wa;
    rd1D    = r1;
    rd2D    = r2;
    ExtImmD = imm;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ValidE"}, 64'(ValidE), 64'd0);
    check({tag, " CtrlE"}, 64'(CtrlE), 64'd0);
    check({tag, " WA3E"}, 64'(WA3E), 64'd0);
    check({tag, " rd1E"}, 64'(rd1E), 64'd0);
    check({tag, " rd2E"}, 64'(rd2E), 64'd0);
    check({tag, " ExtImmE"}, 64'(ExtImmE), 64'd0);
    check({tag, " OccE"}, 64'(OccE), 64'd0);
    check({tag, " StallD"}, 64'(StallD), 64'd0);
  endtask

  // scoreboard-driven stream plus directed steps
  initial begin
    int sent;
    int got;
    int cycles;
    int occ_m;
    logic [W-1:0] exp_item;
    logic [LANE_W-1:0] lane0;

    reset = 1'b1;
    FlushE = 1'b0;
    StallE = 1'b0;
    idle();
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b0;

    // first transaction
    send(8'hA5, 4'd3, 48'h665544332211, 48'h0F0E0D0C0B0A, 8'h7E);
    tick();
    idle();
    check("first ValidE", 64'(ValidE), 64'd1);
    check("first CtrlE", 64'(CtrlE), 64'hA5);
    check("first WA3E", 64'(WA3E), 64'd3);
    check("first rd1E lane0", 64'(rd1E[7:0]), 64'h11);
    check("first rd2E", 64'(rd2E), 64'h0F0E0D0C0B0A);
    check("first ExtImmE", 64'(ExtImmE), 64'h7E);
    check("first OccE", 64'(OccE), 64'd1);
    tick();
    check("bubble ValidE", 64'(ValidE), 64'd0);
    check("bubble CtrlE", 64'(CtrlE), 64'd0);
    check("bubble WA3E", 64'(WA3E), 64'd0);
    check("bubble rd1E held", 64'(rd1E), 64'h665544332211);
    check("bubble ExtImmE held", 64'(ExtImmE), 64'h7E);
    check("bubble OccE", 64'(OccE), 64'd0);

`ifdef SEG_ID_EX_SKID_EN
    // stall fills main then skid
    StallE = 1'b1;
    send(8'h21, 4'd1, 48'h1, 48'h0, 8'h01);
    tick();
    check("skid A WA3E", 64'(WA3E), 64'd1);
    check("skid A OccE", 64'(OccE), 64'd1);
    check("skid A StallD", 64'(StallD), 64'd0);
    send(8'h42, 4'd2, 48'h2, 48'h0, 8'h02);
    tick();
    check("skid B OccE", 64'(OccE), 64'd2);
    check("skid B StallD", 64'(StallD), 64'd1);
    check("skid B WA3E held", 64'(WA3E), 64'd1);
    send(8'h77, 4'd7, 48'h7, 48'h0, 8'h07);
    tick();
    check("skid full OccE", 64'(OccE), 64'd2);
    check("skid full CtrlE", 64'(CtrlE), 64'h21);
    idle();
    StallE = 1'b0;
    tick();
    check("skid drain1 WA3E", 64'(WA3E), 64'd2);
    check("skid drain1 CtrlE", 64'(CtrlE), 64'h42);
    check("skid drain1 OccE", 64'(OccE), 64'd1);
    check("skid drain1 StallD", 64'(StallD), 64'd0);
    tick();
    check("skid drain2 ValidE", 64'(ValidE), 64'd0);
    check("skid drain2 CtrlE", 64'(CtrlE), 64'd0);
    check("skid drain2 OccE", 64'(OccE), 64'd0);
`else
    // combinational back-pressure
    send(8'h21, 4'd1, 48'h1, 48'h0, 8'h01);
    tick();
    check("ns A WA3E", 64'(WA3E), 64'd1);
    StallE = 1'b1;
    send(8'h42, 4'd2, 48'h2, 48'h0, 8'h02);
    #1;
    check("ns StallD same cycle", 64'(StallD), 64'd1);
    tick();
    check("ns stall WA3E stable", 64'(WA3E), 64'd1);
    check("ns stall CtrlE stable", 64'(CtrlE), 64'h21);
    check("ns stall rd1E stable", 64'(rd1E), 64'h1);
    check("ns stall OccE", 64'(OccE), 64'd1);
    StallE = 1'b0;
    #1;
    check("ns StallD release", 64'(StallD), 64'd0);
    tick();
    check("ns swap WA3E", 64'(WA3E), 64'd2);
    check("ns swap ValidE", 64'(ValidE), 64'd1);
    check("ns swap OccE", 64'(OccE), 64'd1);
    idle();
    tick();
    check("ns drain ValidE", 64'(ValidE), 64'd0);
`endif

    // flush at maximum occupancy overrides stall and drops the incoming entry
    StallE = 1'b1;
    send(8'h31, 4'd5, 48'hAB, 48'hCD, 8'h11);
    tick();
`ifdef SEG_ID_EX_SKID_EN
    send(8'h32, 4'd6, 48'hAC, 48'hCE, 8'h12);
    tick();
    check("pre-flush OccE", 64'(OccE), 64'd2);
`else
    check("pre-flush OccE", 64'(OccE), 64'd1);
`endif
    FlushE = 1'b1;
    send(8'h33, 4'd7, 48'hAD, 48'hCF, 8'h13);
    tick();
    FlushE = 1'b0;
    idle();
    #1;
    check_all_zero("flush");
    StallE = 1'b0;
    tick();
    check("post-flush ValidE", 64'(ValidE), 64'd0);

    // stream of 16 with random stall; scoreboard tracks order and occupancy
    sent = 0;
    got = 0;
    cycles = 0;
    occ_m = 0;
    while (got < 16 && cycles < 600) begin
      StallE = ($urandom_range(0, 2) == 0);
      if (sent < 16 && $urandom_range(0, 3) != 0) begin
        lane0 = {4'(sent), 4'h5};
        send({4'(sent), ~4'(sent)}, 4'(sent), {LANES{lane0}}, 48'(sent), 8'(sent));
      end else begin
        idle();
      end
      #1;
      if (ValidE && !StallE) begin
        if (exp_q.size() == 0) begin
          check("stream unexpected output", 64'(WA3E), 64'hFFFF);
        end else begin
          exp_item = exp_q.pop_front();
          check("stream CtrlE", 64'(CtrlE), 64'(exp_item[W-1 -: CTRL_W]));
          check("stream WA3E", 64'(WA3E), 64'(exp_item[LANE_W +: WA_W]));
          check("stream rd1E lane5", 64'(rd1E[DW-1 -: LANE_W]), 64'(exp_item[LANE_W-1:0]));
        end
        got++;
        occ_m--;
      end
      if (ValidD && !StallD) begin
        exp_q.push_back({CtrlD, WA3D, rd1D[LANE_W-1:0]});
        sent++;
        occ_m++;
      end
      tick();
      cycles++;
      check("stream OccE", 64'(OccE), 64'(occ_m));
    end
    idle();
    StallE = 1'b0;
    check("stream all received", 64'(got), 64'd16);
    check("stream queue empty", 64'(exp_q.size()), 64'd0);

    // reset while holding stalled entries
    StallE = 1'b1;
    send(8'h51, 4'd4, 48'h55, 48'h66, 8'h21);
    tick();
`ifdef SEG_ID_EX_SKID_EN
    send(8'h52, 4'd8, 48'h57, 48'h67, 8'h22);
    tick();
    check("pre-reset OccE", 64'(OccE), 64'd2);
`else
    check("pre-reset OccE", 64'(OccE), 64'd1);
`endif
    reset = 1'b1;
    FlushE = 1'b1;
    send(8'h53, 4'd10, 48'h58, 48'h68, 8'h23);
    tick();
    reset = 1'b0;
    FlushE = 1'b0;
    idle();
    #1;
    check_all_zero("mid-stall reset");
    StallE = 1'b0;
    send(8'h5A, 4'd9, 48'h99, 48'h9A, 8'h24);
    tick();
    idle();
    check("post-reset ValidE", 64'(ValidE), 64'd1);
    check("post-reset WA3E", 64'(WA3E), 64'd9);
    check("post-reset CtrlE", 64'(CtrlE), 64'h5A);
    check("post-reset OccE", 64'(OccE), 64'd1);
    tick();
    check("final ValidE", 64'(ValidE), 64'd0);

    // final report
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/seg_id_ex_pipe.md
SEG_ID_EX_PIPE -- requirements
Module: seg_id_ex_pipe

Interface
REQ-001 Parameters, one per line (name, default, meaning) SHALL be:
 LANES, 6, vector lanes per operand;
 LANE_W, 8, bits per lane;
 IMM_W, 8, extended-immediate width;
 CTRL_W, 8, packed control {ALUControl[2:0], RegWrite, MemtoReg, MemWrite, ALUSrc, FlagsWrite};
 WA_W, 4, write-address width.
REQ-002 Ports, one per line (name, direction, width, meaning) SHALL be:
 clk, in, 1, single clock; all state updates on posedge;
 reset, in, 1, synchronous, active-high;
 ValidD, in, 1, decode holds a valid instruction;
 StallD, out, 1, stage cannot accept; decode holds its inputs;
 CtrlD, in, CTRL_W, packed control;
 WA3D, in, WA_W, destination register;
 rd1D, in, LANES x LANE_W, operand 1;
 rd2D, in, LANES x LANE_W, operand 2;
 ExtImmD, in, IMM_W, immediate;
 FlushE, in, 1, discard all held and incoming instructions;
 StallE, in, 1, execute cannot consume;
 ValidE, out, 1, output entry valid;
 CtrlE, out, CTRL_W, control out;
 WA3E, out, WA_W, address out;
 rd1E, out, LANES x LANE_W, operand 1 out;
 rd2E, out, LANES x LANE_W, operand 2 out;
 ExtImmE, out, IMM_W, immediate out;
 OccE, out, 2, entries held (0..2).
REQ-003 Clock SHALL be clk; reset SHALL be reset, synchronous and active-high.

Function
REQ-004 Accept SHALL occur on a posedge with ValidD=1, StallD=0, FlushE=0.
REQ-005 Consume SHALL occur on a posedge with ValidE=1, StallE=0, FlushE=0.
REQ-006 An accepted instruction SHALL appear on the E outputs with ValidE=1 one cycle after acceptance when the stage was empty or consumed that cycle.
REQ-007 CtrlE and WA3E SHALL be 0 whenever ValidE=0 (bubble); rd1E/rd2E/ExtImmE SHALL hold their last value while invalid.
REQ-008 Order SHALL be preserved: entries leave in acceptance order, none duplicated or lost without flush.
REQ-009 FlushE=1 SHALL, at that posedge, invalidate all entries, drop any same-cycle input, set OccE=0, and zero all E outputs; FlushE SHALL override StallE.
REQ-010 Simultaneous accept and consume with OccE=1 SHALL leave OccE=1 with the new entry on the outputs.
REQ-011 While StallE=1 and ValidE=1, all E outputs SHALL remain stable.
REQ-012 OccE SHALL equal the number of valid entries after each posedge.

Reset
REQ-013 With reset=1 at a posedge, all outputs SHALL be 0 next cycle, except StallD, which SHALL also be 0; reset SHALL override FlushE and any in-flight transfer.
REQ-014 Reset asserted mid-stall SHALL discard all entries; the first accept after deassertion SHALL behave as from empty.

Configuration
REQ-015 Macro SEG_ID_EX_SKID_EN SHALL select the buffering mode.
REQ-016 With SEG_ID_EX_SKID_EN defined, the block SHALL hold a main register plus one skid register.
 StallD SHALL be registered, high only when OccE=2.
 An accept while the main entry is held by StallE SHALL land in skid.
 On consume, skid SHALL move to main in the same cycle.
REQ-017 Without SEG_ID_EX_SKID_EN, the block SHALL hold a single register.
 StallD SHALL be combinational: ValidE & StallE & ~FlushE.
 OccE SHALL never exceed 1.

Verification
REQ-018 Reset, then ValidD=1, CtrlD=8'hA5, WA3D=3, rd1D lane0=8'h11, StallE=0 -> next cycle ValidE=1, CtrlE=8'hA5, WA3E=3, rd1E lane0=8'h11, OccE=1.
REQ-019 Skid mode: StallE=1, send A (WA3D=1) then B (WA3D=2) -> OccE=2 and StallD=1 next cycle. Release StallE -> WA3E=1, then WA3E=2, then ValidE=0 with CtrlE=0.
REQ-020 Non-skid mode: ValidE=1, StallE=1 -> StallD=1 the same cycle. Deassert StallE -> StallD=0 the same cycle.
REQ-021 OccE=2 and FlushE=1 with ValidD=1 -> next cycle ValidE=0, OccE=0, CtrlE=0, WA3E=0, StallD=0.
REQ-022 Back-to-back stream of 16 instructions, WA3D=0..15, with random StallE -> WA3E sequence 0..15 exactly once in order.
REQ-023 reset=1 asserted while OccE=2 and StallE=1 -> next cycle all outputs 0; first instruction after reset appears after 1 cycle.
